mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch (I) side and the data-access (D) side of the 5-stage pipeline.
- Arbitrates between the two sides and sequences each transfer through a request/ack handshake.
- Drives per-side stall outputs; the pipeline uses them to freeze PC/IFID (I side) and the whole pipeline (D side) while an access is outstanding.
- Guards against a hung memory with a timeout watchdog, and prevents I-side starvation.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, maximum cycles from mem_req_o assertion to mem_ack_i before abort. Range 2..255.
- MAX_WAIT, 4, cycles a pending I request may lose arbitration before it is forced to win. Range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- i_req_i  in  1  fetch request; held until i_ack_o.
- i_addr_i  in  AW  fetch address.
- i_ack_o  out  1  one-cycle pulse: fetch complete.
- i_rdata_o  out  DW  fetch data; valid when i_ack_o=1.
- i_stall_o  out  1  i_req_i & ~i_ack_o.
- d_req_i  in  1  data request; held until d_ack_o.
- d_we_i  in  1  1=write, 0=read.
- d_addr_i  in  AW  data address.
- d_wdata_i  in  DW  write data.
- d_ack_o  out  1  one-cycle pulse: data access complete.
- d_rdata_o  out  DW  read data; valid when d_ack_o=1.
- d_stall_o  out  1  d_req_i & ~d_ack_o.
- mem_req_o  out  1  backing-memory request; held until mem_ack_i or timeout.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_ack_i  in  1  one-cycle completion from memory.
- mem_rdata_i  in  DW  memory read data; valid with mem_ack_i.
- err_o  out  1  one-cycle pulse together with an ack that was caused by timeout.

Behaviour:
- States: IDLE, BUSY, RESP.
  - IDLE: arbitrate.
  - BUSY: mem_req_o held.
  - RESP: ack pulse to the granted side.
- Reset (rst_i=0, any state, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, except stall outputs, which follow their combinational definition.
  - Wait counter and timeout counter are 0; grant register is I.
- IDLE:
  - If either request is pending, latch the winner's addr/we/wdata into registers and go to BUSY.
  - mem_req_o rises in the next cycle. D-side writes latch d_we_i=1; the I side always latches we=0.
- Fixed priority: D wins over I, except when wait_cnt==MAX_WAIT, in which case I wins.
- Wait counter:
  - wait_cnt increments in each IDLE cycle where I is pending and D wins.
  - It clears when I is granted or i_req_i=0.
  - It saturates at MAX_WAIT.
- BUSY:
  - mem_* outputs are driven from the latched registers and are stable throughout BUSY.
  - tmo_cnt increments every cycle.
  - If mem_ack_i=1: capture mem_rdata_i and go to RESP.
  - Else if tmo_cnt==TIMEOUT-1: drop mem_req_o, set captured data to 0, set the error flag, and go to RESP.
  - If mem_ack_i and the timeout coincide, the ack wins and there is no error.
- RESP:
  - Pulse the granted side's ack_o for exactly one cycle, with rdata_o = captured data.
  - err_o = error flag.
  - Return to IDLE and clear tmo_cnt.
  - The ungranted side's ack_o stays 0 and its rdata_o holds.
- Latency: request sampled in IDLE at cycle N gives mem_req_o at N+1. mem_ack_i at cycle M gives ack_o at M+1. The next arbitration happens at M+2. Minimum 3 cycles per access.
- rdata_o outputs hold their last value between acks.
- Requests deasserted while BUSY: the transfer still completes and the ack is still pulsed. The requester must ignore it.
- mem_ack_i outside BUSY is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - When both sides are pending, the side not granted last wins; the grant register updates on each grant.
  - A single pending side always wins.
  - The wait counter and MAX_WAIT logic are not compiled.
- Undefined: fixed D priority with MAX_WAIT starvation override, as described above.

Test Plan:
- Reset then I-only read: i_req_i=1, addr=0x10; memory acks 2 cycles after mem_req_o with 0xDEADBEEF.
  - Expect mem_addr_o=0x10 and mem_we_o=0.
  - Expect i_ack_o to pulse once with i_rdata_o=0xDEADBEEF.
  - Expect i_stall_o=1 until the ack cycle.
- Simultaneous I (addr 0x20) and D write (addr 0x40, data 0x5A5A5A5A), macro undefined.
  - First memory transaction: addr 0x40 with we=1, followed by d_ack_o.
  - Second transaction: addr 0x20, followed by i_ack_o.
- Starvation, macro undefined: d_req_i re-asserted continuously with back-to-back requests, i_req_i held.
  - I is granted no later than its 5th arbitration (MAX_WAIT=4).
- Same back-to-back D and held I stimulus, macro defined: grants alternate D, I, D, I.
- Timeout: memory never acks.
  - mem_req_o drops after exactly 64 cycles.
  - The granted side sees ack_o=1, rdata_o=0 and err_o=1 in the same cycle.
  - The next request is served normally.
- Asynchronous reset asserted mid-BUSY.
  - mem_req_o, all ack outputs and err_o are 0 immediately, without waiting for a clock edge.
  - After release, a pending request restarts from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port backing memory between the
// instruction-fetch (I) and data-access (D) sides of the pipeline.
// Sequences each access IDLE -> BUSY -> RESP, with a timeout watchdog
// and per-side stall outputs.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, D has fixed priority and MAX_WAIT bounds
// how long a pending I request can be starved.
module mem_port_arbiter #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // instruction-fetch side
   input  logic          i_req_i,
   input  logic [AW-1:0] i_addr_i,
   output logic          i_ack_o,
   output logic [DW-1:0] i_rdata_o,
   output logic          i_stall_o,
   // data-access side
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_ack_o,
   output logic [DW-1:0] d_rdata_o,
   output logic          d_stall_o,
   // backing memory
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic          mem_ack_i,
   input  logic [DW-1:0] mem_rdata_i,
   // timeout indication
   output logic          err_o
);

   localparam int unsigned TmoW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            gnt_dside_q, gnt_dside_d;   // 1: D side owns the transfer
   logic            mem_req_q, mem_req_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            i_ack_q, i_ack_d;
   logic            d_ack_q, d_ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   i_rdata_q, i_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;

   logic            i_win_c;
   logic            d_win_c;
   logic            tmo_hit_c;
   logic [DW-1:0]   resp_data_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Round-robin: on contention the side not granted last wins.
   always_comb begin
      i_win_c = 1'b0;
      d_win_c = 1'b0;
      if (i_req_i && d_req_i) begin
         d_win_c = ~gnt_dside_q;
         i_win_c = gnt_dside_q;
      end else begin
         i_win_c = i_req_i;
         d_win_c = d_req_i;
      end
   end
`else
   localparam int unsigned WaitW = 4;

   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             wait_full_c;

   assign wait_full_c = (wait_cnt_q == WaitW'(MAX_WAIT));

   // Fixed D priority, overridden once I has lost MAX_WAIT times.
   always_comb begin
      i_win_c = i_req_i & (~d_req_i | wait_full_c);
      d_win_c = d_req_i & ~i_win_c;
   end

   // Starvation counter: counts IDLE losses of a pending I request.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!i_req_i) begin
         wait_cnt_d = '0;
      end else if (state_q == IDLE) begin
         if (i_win_c) begin
            wait_cnt_d = '0;
         end else if (!wait_full_c) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`endif

   assign tmo_hit_c   = (tmo_cnt_q == TmoW'(TIMEOUT - 1));
   // A real ack always beats a coinciding timeout.
   assign resp_data_c = mem_ack_i ? mem_rdata_i : '0;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      gnt_dside_d = gnt_dside_q;
      mem_req_d   = mem_req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tmo_cnt_d   = tmo_cnt_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (i_win_c || d_win_c) begin
               gnt_dside_d = d_win_c;
               addr_d      = d_win_c ? d_addr_i : i_addr_i;
               we_d        = d_win_c & d_we_i;
               wdata_d     = d_win_c ? d_wdata_i : '0;
               mem_req_d   = 1'b1;
               tmo_cnt_d   = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            if (mem_ack_i || tmo_hit_c) begin
               mem_req_d = 1'b0;
               err_d     = ~mem_ack_i;
               state_d   = RESP;
               if (gnt_dside_q) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = resp_data_c;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = resp_data_c;
               end
            end
         end
         RESP: begin
            tmo_cnt_d = '0;
            state_d   = IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            tmo_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latched request, counters and response registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         gnt_dside_q <= 1'b0;
         mem_req_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         tmo_cnt_q   <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         gnt_dside_q <= gnt_dside_d;
         mem_req_q   <= mem_req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tmo_cnt_q   <= tmo_cnt_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         err_q       <= err_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign i_ack_o     = i_ack_q;
   assign d_ack_o     = d_ack_q;
   assign err_o       = err_q;
   assign i_rdata_o   = i_rdata_q;
   assign d_rdata_o   = d_rdata_q;

   // Stalls follow the live request so the pipeline freezes on the same cycle.
   assign i_stall_o   = i_req_i & ~i_ack_q;
   assign d_stall_o   = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: cycle vector table for the basic
// read/write/contention flow, plus directed sequences for starvation,
// timeout and asynchronous reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req_i;
   logic [31:0] i_addr_i;
   logic        i_ack_o;
   logic [31:0] i_rdata_o;
   logic        i_stall_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_ack_o;
   logic [31:0] d_rdata_o;
   logic        d_stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   int checks;
   int errors;

   logic        auto_ack;
   logic [31:0] auto_rdata;

   mem_port_arbiter #(
      .AW(32), .DW(32), .TIMEOUT(64), .MAX_WAIT(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_n),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o),
      .i_rdata_o(i_rdata_o), .i_stall_o(i_stall_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
      .d_stall_o(d_stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle vector: inputs applied before an edge, outputs expected after it.
   // e_ctl = {mem_req, mem_we, i_ack, d_ack, err, i_stall, d_stall}
   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic [6:0]  e_ctl;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dw,
      input logic ma, input logic [31:0] md,
      input logic [6:0] ec, input logic [31:0] ea, input logic [31:0] ew,
      input logic [31:0] eir, input logic [31:0] edr);
      vec_t v;
      v.i_req = ir;  v.i_addr = ia;
      v.d_req = dr;  v.d_we = dwe; v.d_addr = da; v.d_wdata = dw;
      v.mem_ack = ma; v.mem_rdata = md;
      v.e_ctl = ec;  v.e_addr = ea; v.e_wdata = ew;
      v.e_irdata = eir; v.e_drdata = edr;
      return v;
   endfunction

   function automatic logic [159:0] snap();
      return {25'd0, mem_req_o, mem_we_o, i_ack_o, d_ack_o, err_o, i_stall_o,
              d_stall_o, mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o};
   endfunction

   task automatic check(input string name, input logic [159:0] act,
                        input logic [159:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // One clock with the auto-responding memory model: acks in the first BUSY cycle.
   task automatic tick();
      @(negedge clk);
      mem_ack_i   = auto_ack & mem_req_o;
      mem_rdata_i = auto_rdata;
      @(posedge clk);
      #1;
   endtask

   logic [5:0]  grants;
   logic [5:0]  exp_grants;
   int          ngr;
   int          g0;
   int          g1;
   int          busy_n;
   logic        prev_req;
   logic        got;

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      i_req_i = 1'b0; i_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      auto_ack = 1'b0; auto_rdata = '0;

      #1;
      check("reset_outputs", snap(), 160'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b1000010, 32'h10, 32'h0, 32'h0, 32'h0);
      vecs[1]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b1000010, 32'h10, 32'h0, 32'h0, 32'h0);
      vecs[2]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b1000010, 32'h10, 32'h0, 32'h0, 32'h0);
      vecs[3]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,        1, 32'hDEADBEEF,
                    7'b0010000, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
      vecs[4]  = mk(0, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b0000000, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
      vecs[5]  = mk(1, 32'h20, 1, 1, 32'h40, 32'h5A5A5A5A, 0, 32'h0,
                    7'b1100011, 32'h40, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0);
      vecs[6]  = mk(1, 32'h20, 1, 1, 32'h40, 32'h5A5A5A5A, 1, 32'hCAFE0001,
                    7'b0101010, 32'h40, 32'h5A5A5A5A, 32'hDEADBEEF, 32'hCAFE0001);
      vecs[7]  = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b0100010, 32'h40, 32'h5A5A5A5A, 32'hDEADBEEF, 32'hCAFE0001);
      vecs[8]  = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b1000010, 32'h20, 32'h0, 32'hDEADBEEF, 32'hCAFE0001);
      vecs[9]  = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,        1, 32'h12345678,
                    7'b0010000, 32'h20, 32'h0, 32'h12345678, 32'hCAFE0001);
      vecs[10] = mk(0, 32'h20, 0, 0, 32'h0,  32'h0,        0, 32'h0,
                    7'b0000000, 32'h20, 32'h0, 32'h12345678, 32'hCAFE0001);
      vecs[11] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,        1, 32'hFFFFFFFF,
                    7'b0000000, 32'h20, 32'h0, 32'h12345678, 32'hCAFE0001);

      // Vector table: I-only read, D write vs I contention, stray mem ack.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         i_req_i = vecs[k].i_req;  i_addr_i = vecs[k].i_addr;
         d_req_i = vecs[k].d_req;  d_we_i = vecs[k].d_we;
         d_addr_i = vecs[k].d_addr; d_wdata_i = vecs[k].d_wdata;
         mem_ack_i = vecs[k].mem_ack; mem_rdata_i = vecs[k].mem_rdata;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", k), snap(),
               {25'd0, vecs[k].e_ctl, vecs[k].e_addr, vecs[k].e_wdata,
                vecs[k].e_irdata, vecs[k].e_drdata});
      end

      // Contention with both sides held: record the first six grants (1 = D).
      mem_ack_i = 1'b0;
      auto_ack = 1'b1; auto_rdata = 32'h0BADF00D;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80; d_wdata_i = '0;
      i_req_i = 1'b1; i_addr_i = 32'h24;
      grants = '0; ngr = 0; g0 = 0; g1 = 0; prev_req = mem_req_o;
      for (int c = 0; c < 100; c++) begin
         if (ngr >= 6) break;
         tick();
         if (mem_req_o && !prev_req) begin
            grants = {grants[4:0], (mem_addr_o == 32'h80)};
            if (ngr == 0) g0 = c;
            if (ngr == 1) g1 = c;
            ngr++;
         end
         prev_req = mem_req_o;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_grants = 6'b101010;
`else
      exp_grants = 6'b111101;
`endif
      check("grant_count", 160'(ngr), 160'd6);
      check("grant_order", 160'(grants), 160'(exp_grants));
      check("access_gap", 160'(g1 - g0), 160'd3);
      d_req_i = 1'b0; i_req_i = 1'b0;
      repeat (4) tick();

      // Timeout: memory never acks.
      auto_ack = 1'b0;
      i_req_i = 1'b1; i_addr_i = 32'h30;
      busy_n = 0;
      tick();
      for (int c = 0; c < 300; c++) begin
         if (!mem_req_o) break;
         busy_n++;
         tick();
      end
      check("tmo_busy_cycles", 160'(busy_n), 160'd64);
      check("tmo_resp", {127'd0, i_ack_o, d_ack_o, err_o, i_rdata_o},
            {127'd0, 1'b1, 1'b0, 1'b1, 32'h0});
      i_req_i = 1'b0;
      tick();
      check("tmo_err_pulse", {157'd0, i_ack_o, err_o, mem_req_o}, 160'd0);

      // Request after a timeout is served normally.
      auto_ack = 1'b1; auto_rdata = 32'h600DCAFE;
      i_req_i = 1'b1; i_addr_i = 32'h34;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (i_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      check("post_tmo_read", {94'd0, got, err_o, mem_addr_o, i_rdata_o},
            {94'd0, 1'b1, 1'b0, 32'h34, 32'h600DCAFE});
      i_req_i = 1'b0;
      tick();

      // Asynchronous reset in the middle of BUSY.
      auto_ack = 1'b0;
      i_req_i = 1'b1; i_addr_i = 32'h44;
      tick();
      tick();
      check("pre_reset_busy", {159'd0, mem_req_o}, {159'd0, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {91'd0, mem_req_o, i_ack_o, d_ack_o, err_o, i_stall_o,
                            mem_addr_o, i_rdata_o},
            {91'd0, 5'b00001, 32'h0, 32'h0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_release_idle", {159'd0, mem_req_o}, 160'd0);
      @(posedge clk);
      #1;
      check("restart_grant", {127'd0, mem_req_o, mem_addr_o},
            {127'd0, 1'b1, 32'h44});
      auto_ack = 1'b1; auto_rdata = 32'h44440044;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (i_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      check("restart_read", {126'd0, got, err_o, i_rdata_o},
            {126'd0, 1'b1, 1'b0, 32'h44440044});
      i_req_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
